// File: rtl/board_arb_pkg.sv
// board_arb_pkg: shared types and constants for the board RAM arbiter.
package board_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_e;

    localparam int BOARD_DEPTH = 200;
    localparam int CELL_W      = 3;
    localparam logic [CELL_W-1:0] CELL_EMPTY = '0;

endpackage

// File: rtl/board_clear_seq.sv
// board_clear_seq: walks the clear pointer over the board, one cell per blanking cycle.
module board_clear_seq #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 200
) (
    input  logic              pclk,
    input  logic              rstn,
    input  logic              start,
    input  logic              active,
    input  logic              disp_en,
    output logic              adv,
    output logic              done,
    output logic [ADDR_W-1:0] clr_ptr
);

    logic [ADDR_W-1:0] clr_ptr_d, clr_ptr_q;

    always_comb begin
        adv       = active && !disp_en;
        done      = adv && (clr_ptr_q == ADDR_W'(DEPTH - 1));
        clr_ptr_d = (start || done) ? '0 : adv ? clr_ptr_q + ADDR_W'(1) : clr_ptr_q;
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) clr_ptr_q <= '0;
        else       clr_ptr_q <= clr_ptr_d;
    end

    assign clr_ptr = clr_ptr_q;

endmodule

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: shares one board RAM port between display, clear sequencer and engine.
// Optional stall counter output when BOARD_ARB_STATS_EN is defined.
module board_mem_arbiter
    import board_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = CELL_W,
    parameter int DEPTH  = BOARD_DEPTH
) (
    input  logic              pclk,
    input  logic              rstn,
    input  logic              disp_en,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [DATA_W-1:0] eng_rdata,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef BOARD_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    arb_state_e        state_d, state_q;
    logic              clr_start, clr_adv, clr_done;
    logic [ADDR_W-1:0] clr_ptr;
    logic              g_clr, g_eng;
    logic              disp_rd_d, disp_rd_q, eng_rd_d, eng_rd_q;
    logic [DATA_W-1:0] disp_hold_d, disp_hold_q, eng_hold_d, eng_hold_q;

    board_clear_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_clr (
        .pclk    (pclk),
        .rstn    (rstn),
        .start   (clr_start),
        .active  (state_q == CLEAR),
        .disp_en (disp_en),
        .adv     (clr_adv),
        .done    (clr_done),
        .clr_ptr (clr_ptr)
    );

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        clr_start = (state_q == IDLE) && clr_req;
        state_d   = clr_start ? CLEAR : clr_done ? IDLE : state_q;
    end

    // Outputs are forced low while rstn is asserted so the RAM sees no access during reset.
    always_comb begin
        g_clr     = !disp_en && (state_q == CLEAR);
        g_eng     = !disp_en && (state_q == IDLE) && eng_req && !clr_req;
        eng_gnt   = rstn && g_eng;
        clr_busy  = state_q == CLEAR;
        mem_en    = rstn && (disp_en || clr_adv || g_eng);
        mem_we    = rstn && (clr_adv || (g_eng && eng_we));
        mem_addr  = !rstn ? '0 : disp_en ? disp_addr : g_clr ? clr_ptr : g_eng ? eng_addr : '0;
        mem_wdata = (rstn && g_eng) ? eng_wdata : DATA_W'(CELL_EMPTY);
    end

    always_comb begin
        disp_rd_d   = disp_en;
        eng_rd_d    = g_eng && !eng_we;
        disp_rdata  = disp_rd_q ? mem_rdata : disp_hold_q;
        eng_rvalid  = eng_rd_q;
        eng_rdata   = eng_rd_q ? mem_rdata : eng_hold_q;
        disp_hold_d = disp_rdata;
        eng_hold_d  = eng_rdata;
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            disp_rd_q   <= 1'b0;
            eng_rd_q    <= 1'b0;
            disp_hold_q <= '0;
            eng_hold_q  <= '0;
        end else begin
            disp_rd_q   <= disp_rd_d;
            eng_rd_q    <= eng_rd_d;
            disp_hold_q <= disp_hold_d;
            eng_hold_q  <= eng_hold_d;
        end
    end

`ifdef BOARD_ARB_STATS_EN
    logic [15:0] stall_cnt_d, stall_cnt_q;

    always_comb begin
        stall_cnt_d = clr_start ? '0
                    : (eng_req && !g_eng && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1
                    : stall_cnt_q;
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
